chess_button_conditioner: RTL and testbench

Input front end for the chess clock. It takes the three raw, asynchronous push-buttons (`button1`, `button2`, `start_button`) and synchronises and debounces each one. It produces clean level signals and single-cycle press pulses for the chess clock core, which consumes `deb_button1`, `deb_button2` and `start`. It also adds two functions: rejection of simultaneous player presses, and a long-press-on-start reset request.

---
 rtl/chess_pkg.sv | 15 +
 rtl/debounce_channel.sv | 97 +++++++++
 rtl/chess_button_conditioner.sv | 106 ++++++++++
 tb/tb_chess_button_conditioner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared types and default timing constants for the chess clock input front end.
package chess_pkg;

  // Per-button debounce state.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_e;

  localparam int DEB_CYCLES_DEF  = 4;
  localparam int LONG_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and stability counter.
// 'accept' is a decode of registered state, asserted in the cycle whose
// closing edge moves PRESS_WAIT -> HELD, so the top can register it as a pulse.
module debounce_channel
  import chess_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic accept,
  output logic held
);

  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_CYCLES);

  logic [1:0]       sync_q, sync_d;
  logic             in_sync;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  assign sync_d  = {sync_q[0], raw};
  assign in_sync = sync_q[1];

  // State, counter, synchroniser and level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Debounce FSM: a level change is accepted only after DEB_CYCLES stable samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!in_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_TERM) begin
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!in_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (in_sync) begin
          // Bounce during release: back to HELD without a new press.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_TERM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  assign level = level_q;
  assign held  = (state_q == HELD);

endmodule

// File: rtl/chess_button_conditioner.sv
// Chess clock input front end: three debounced buttons, press pulses,
// simultaneous-press rejection and a long-press-on-start reset request.
module chess_button_conditioner
  import chess_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic button1,
  input  logic button2,
  input  logic start_button,
  output logic deb_button1,
  output logic deb_button2,
  output logic deb_start,
  output logic press1,
  output logic press2,
  output logic start,
  output logic reset_req,
  output logic conflict
);

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  // Channel index: 0 = player 1, 1 = player 2, 2 = start.
  logic [2:0] raw_vec;
  logic [2:0] level_vec;
  logic [2:0] accept_vec;
  logic [2:0] held_vec;
  logic       unused_held;

  assign raw_vec     = {start_button, button2, button1};
  assign unused_held = |held_vec[1:0];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      debounce_channel #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_vec[gi]),
        .level (level_vec[gi]),
        .accept(accept_vec[gi]),
        .held  (held_vec[gi])
      );
    end
  endgenerate

  logic             press1_q, press1_d;
  logic             press2_q, press2_d;
  logic             start_q, start_d;
  logic             conflict_q, conflict_d;
  logic             reset_req_q, reset_req_d;
  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;

  // Arbitration of player presses and the saturating long-press counter.
  always_comb begin
    press1_d    = accept_vec[0] & ~accept_vec[1];
    press2_d    = accept_vec[1] & ~accept_vec[0];
    conflict_d  = accept_vec[0] & accept_vec[1];
    start_d     = accept_vec[2];
    long_cnt_d  = long_cnt_q;
    reset_req_d = 1'b0;
    if (!level_vec[2]) begin
      // Start fully released: arm for the next hold.
      long_cnt_d = '0;
    end else if (held_vec[2] && (long_cnt_q != LONG_TERM)) begin
      long_cnt_d  = long_cnt_q + CNT_W'(1);
      reset_req_d = (long_cnt_q == LONG_LAST);
    end
  end

  // Output pulse registers and long-press counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      press1_q    <= 1'b0;
      press2_q    <= 1'b0;
      start_q     <= 1'b0;
      conflict_q  <= 1'b0;
      reset_req_q <= 1'b0;
      long_cnt_q  <= '0;
    end else begin
      press1_q    <= press1_d;
      press2_q    <= press2_d;
      start_q     <= start_d;
      conflict_q  <= conflict_d;
      reset_req_q <= reset_req_d;
      long_cnt_q  <= long_cnt_d;
    end
  end

  assign deb_button1 = level_vec[0];
  assign deb_button2 = level_vec[1];
  assign deb_start   = level_vec[2];
  assign press1      = press1_q;
  assign press2      = press2_q;
  assign start       = start_q;
  assign reset_req   = reset_req_q;
  assign conflict    = conflict_q;

endmodule

// File: tb/tb_chess_button_conditioner.sv
// Directed bench for chess_button_conditioner (DEB_CYCLES=4, LONG_CYCLES=16).
// Edge n is the n-th rising edge after reset is released; inputs for edge n
// are set just after edge n-1, outputs are read 1 time unit after edge n.
// Output vector order: {deb1, deb2, deb_start, press1, press2, start, reset_req, conflict}.
module tb_chess_button_conditioner;

  logic clk;
  logic reset;
  logic button1, button2, start_button;
  logic deb_button1, deb_button2, deb_start;
  logic press1, press2, start, reset_req, conflict;

  int checks = 0;
  int passes = 0;

  chess_button_conditioner dut (
    .clk         (clk),
    .reset       (reset),
    .button1     (button1),
    .button2     (button2),
    .start_button(start_button),
    .deb_button1 (deb_button1),
    .deb_button2 (deb_button2),
    .deb_start   (deb_start),
    .press1      (press1),
    .press2      (press2),
    .start       (start),
    .reset_req   (reset_req),
    .conflict    (conflict)
  );

  wire [7:0] obs = {deb_button1, deb_button2, deb_start, press1, press2, start, reset_req, conflict};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    button1 = 1'b0;
    button2 = 1'b0;
    start_button = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    reset = 1'b1;
    button1 = 1'b1;
    button2 = 1'b1;
    start_button = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      exp = 8'b0;
      checks++;
      if (obs !== exp) $display("FAIL reset n=%0d got=%b exp=%b", n, obs, exp);
      else passes++;
    end
    do_reset();
  endtask

  task automatic test_glitch();
    logic [7:0] exp;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      button2 = (n == 2) || (n >= 6 && n <= 8);
      tick();
      exp = 8'b0;
      checks++;
      if (obs !== exp) $display("FAIL glitch n=%0d got=%b exp=%b", n, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_min_width();
    logic [7:0] exp;
    do_reset();
    for (int n = 0; n < 36; n++) begin
      button1 = (n <= 3) || (n >= 20 && n <= 24);
      tick();
      exp = {(n >= 26 && n < 31), 1'b0, 1'b0, (n == 26), 4'b0};
      checks++;
      if (obs !== exp) $display("FAIL min_width n=%0d got=%b exp=%b", n, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] exp;
    do_reset();
    for (int n = 0; n < 35; n++) begin
      button1 = (n >= 10 && n <= 21);
      tick();
      exp = {(n >= 16 && n < 28), 1'b0, 1'b0, (n == 16), 4'b0};
      checks++;
      if (obs !== exp) $display("FAIL clean_press n=%0d got=%b exp=%b", n, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_release_bounce();
    logic [7:0] exp;
    do_reset();
    for (int n = 0; n < 32; n++) begin
      button1 = (n <= 14) || (n >= 17 && n <= 19);
      tick();
      exp = {(n >= 6 && n < 26), 1'b0, 1'b0, (n == 6), 4'b0};
      checks++;
      if (obs !== exp) $display("FAIL release_bounce n=%0d got=%b exp=%b", n, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      button1 = (n <= 9);
      button2 = (n <= 9);
      tick();
      exp = {(n >= 6 && n < 16), (n >= 6 && n < 16), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (n == 6)};
      checks++;
      if (obs !== exp) $display("FAIL simultaneous n=%0d got=%b exp=%b", n, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_long_start();
    logic [7:0] exp;
    do_reset();
    for (int n = 0; n < 92; n++) begin
      start_button = (n <= 29) || (n >= 32 && n <= 41) || (n >= 55 && n <= 80);
      tick();
      exp = {1'b0, 1'b0, ((n >= 6 && n < 48) || (n >= 61 && n < 87)), 1'b0, 1'b0,
             (n == 6 || n == 61), (n == 22 || n == 77), 1'b0};
      checks++;
      if (obs !== exp) $display("FAIL long_start n=%0d got=%b exp=%b", n, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_press();
    logic [7:0] exp;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      button1 = (n <= 5);
      reset = (n >= 4 && n <= 7);
      tick();
      exp = 8'b0;
      checks++;
      if (obs !== exp) $display("FAIL reset_mid_press n=%0d got=%b exp=%b", n, obs, exp);
      else passes++;
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_held();
    logic [7:0] exp;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      button1 = 1'b1;
      reset = (n == 8);
      tick();
      exp = {((n >= 6 && n < 8) || n >= 15), 1'b0, 1'b0, (n == 6 || n == 15), 4'b0};
      checks++;
      if (obs !== exp) $display("FAIL reset_held n=%0d got=%b exp=%b", n, obs, exp);
      else passes++;
    end
    reset = 1'b0;
    button1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    button1 = 1'b0;
    button2 = 1'b0;
    start_button = 1'b0;
    test_reset();
    test_glitch();
    test_min_width();
    test_clean_press();
    test_release_bounce();
    test_simultaneous();
    test_long_start();
    test_reset_mid_press();
    test_reset_held();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
